mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single VeriRISC instruction/data memory between the CPU datapath and a debug/loader port. It serialises transactions with a fixed per-transaction sequence and returns read data through a one-cycle ack. It gives the CPU priority, with a starvation bound for the debug port. It sits between the CPU bus and the memory, which has a 1-cycle read latency.

## Interface
- ADDR_WIDTH, 5, memory address width
- DATA_WIDTH, 8, memory data width
- STARVE_LIMIT, 4, number of consecutive CPU grants while dbg_req is pending before debug is forced to win (≥1)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU transaction request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- cpu_rdata  out  DATA_WIDTH  last CPU read data (registered, holds)
- dbg_req / dbg_we / dbg_addr / dbg_wdata  in  1/1/ADDR_WIDTH/DATA_WIDTH  debug port, same semantics as CPU
- dbg_ack  out  1  one-cycle completion pulse to debug
- dbg_rdata  out  DATA_WIDTH  last debug read data (registered, holds)
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable (qualified by mem_en)
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en
- owner  out  1  0 = CPU, 1 = debug; current/last granted port
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE → ISSUE → RESP → ACK → IDLE. No other transitions. ISSUE, RESP and ACK always advance unconditionally.
- IDLE: sample cpu_req/dbg_req. If neither is high, stay in IDLE. If either is high, select the winner, latch its we/addr/wdata into the mem_* registers, set owner, and go to ISSUE.
- Winner rule:
  - Only one requester high → that requester wins.
  - Both high → CPU wins, unless starve_cnt == STARVE_LIMIT, in which case debug wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when CPU is granted while dbg_req is high.
  - Clears when debug is granted, or when dbg_req is sampled low in IDLE.
- ISSUE: mem_en = 1 for exactly this cycle, with latched we/addr/wdata.
- RESP: if the transaction is a read, capture mem_rdata into the winner's rdata register at the end of this cycle. Writes leave both rdata registers unchanged.
- ACK: the winner's ack is high for exactly this cycle. The other ack stays 0.
- mem_addr/mem_wdata/mem_we hold their last values outside ISSUE. They are don't-care while mem_en = 0.
- Requester fields must be stable from req high until ack. Changes after the IDLE sample are ignored.
- The ack cycle returns the FSM to IDLE. A req still high in the following IDLE cycle starts a new transaction; no edge detection.
- Reset values: state IDLE, cpu_ack/dbg_ack/mem_en/mem_we 0, mem_addr/mem_wdata 0, cpu_rdata/dbg_rdata 0, owner 0, starve_cnt 0, busy 0.
- Reset mid-transaction (any state) aborts immediately:
  - No ack is issued.
  - No rdata update.
  - If in ISSUE, mem_en drops in the cycle after rst is sampled.

## Timing
- Cycle numbering: cycle 0 is IDLE with req sampled high.
- Cycle 1: ISSUE, mem_en = 1.
- Cycle 2: RESP, mem_rdata valid, captured at the end of the cycle.
- Cycle 3: ACK, ack = 1, rdata already shows the new value.
- Cycle 4: IDLE.
- Request-to-ack latency: 3 cycles. Minimum spacing: 4 cycles per transaction, i.e. back-to-back requests are granted every 4 cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- busy is high in cycles 1–3.

## Test plan
- Reset, then CPU read of addr 5 with memory holding 0xA3 → mem_en high only in cycle 1 with mem_addr=5, mem_we=0; cpu_ack high only in cycle 3; cpu_rdata=0xA3; dbg_ack stays 0.
- Debug write 0x5C to addr 12, then CPU read of addr 12 → debug write acked with owner=1 and dbg_rdata unchanged (0); CPU read acked 4 cycles later with cpu_rdata=0x5C.
- cpu_req and dbg_req rise in the same cycle, CPU dropping req after its ack → CPU granted first (owner=0); debug granted in the next IDLE window (owner=1).
- STARVE_LIMIT=4, cpu_req and dbg_req held high continuously → grant sequence C,C,C,C,D,C,C,C,C,D; one ack every 4 cycles.
- rst asserted during RESP of a CPU read → no cpu_ack; cpu_rdata=0; FSM in IDLE the next cycle; a fresh request completes normally.
- CPU write 0xFF after a prior read of 0x11 → cpu_rdata stays 0x11; mem_we=1 with mem_en in the ISSUE cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port memory arbiter, CPU priority with debug starvation bound
//
// Purpose: shares one single-port memory (1-cycle read latency) between the
// CPU bus and a debug/loader port. Each transaction runs the fixed sequence
// IDLE -> ISSUE -> RESP -> ACK -> IDLE. Read data returns in a registered
// per-port rdata register, and a one-cycle ack pulse marks completion.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata             CPU completion pulse, last CPU read data
//   dbg_req/we/addr/wdata          debug request, held until dbg_ack
//   dbg_ack, dbg_rdata             debug completion pulse, last debug read data
//   mem_en/we/addr/wdata           memory strobe and latched command
//   mem_rdata                      memory read data, valid the cycle after mem_en
//   owner                          0 = CPU, 1 = debug (current/last grant)
//   busy                           high whenever the FSM is not IDLE
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  owner,
  output logic                  busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_d;
  logic [CW-1:0]         starve_cnt;
  logic [CW-1:0]         starve_cnt_d;
  logic                  grant;
  logic                  grant_dbg;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Next-state, arbitration and starvation counter update.
  always_comb begin
    state_d      = state;
    starve_cnt_d = starve_cnt;
    grant        = 1'b0;
    grant_dbg    = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant     = 1'b1;
          // CPU wins ties unless debug has waited out STARVE_LIMIT CPU grants.
          grant_dbg = dbg_req && (!cpu_req || (starve_cnt == STARVE_MAX));
          state_d   = ISSUE;
        end
        // Any IDLE sample with dbg_req low, or a debug grant, forgives the wait.
        if (grant_dbg || !dbg_req) begin
          starve_cnt_d = '0;
        end else if (grant && (starve_cnt != STARVE_MAX)) begin
          starve_cnt_d = starve_cnt + 1'b1;
        end
      end
      ISSUE:   state_d = RESP;
      RESP:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command fields of the winning port.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (grant_dbg) begin
      sel_we    = dbg_we;
      sel_addr  = dbg_addr;
      sel_wdata = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_cnt_d;
    end
  end

  // All outputs are flops decoded from the next state, so nothing on an
  // input reaches an output without passing through a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_en  <= (state_d == ISSUE);
      busy    <= (state_d != IDLE);
      cpu_ack <= (state_d == ACK) && !owner;
      dbg_ack <= (state_d == ACK) && owner;

      if (grant) begin
        owner     <= grant_dbg;
        mem_we    <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end

      // mem_we still holds the latched command during RESP.
      if ((state == RESP) && !mem_we) begin
        if (owner) begin
          dbg_rdata <= mem_rdata;
        end else begin
          cpu_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [4:0] cpu_addr, dbg_addr;
  logic [7:0] cpu_wdata, dbg_wdata;
  logic       cpu_ack, dbg_ack;
  logic [7:0] cpu_rdata, dbg_rdata;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       owner, busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         dbg;
    logic [7:0] cpu_rd;
    logic [7:0] dbg_rd;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:31];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  // Synchronous memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ack pops the oldest expected grant.
  always @(negedge clk) begin
    if (cpu_ack || dbg_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, dbg_ack, cpu_ack}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_port_dbg", dbg_ack, e.dbg);
        chk("ack_port_cpu", cpu_ack, !e.dbg);
        chk("ack_owner", owner, e.dbg);
        chk("ack_cpu_rdata", cpu_rdata, e.cpu_rd);
        chk("ack_dbg_rdata", dbg_rdata, e.dbg_rd);
      end
    end
  end

  task automatic push(input bit d, input logic [7:0] crd, input logic [7:0] drd);
    exp_t e;
    e.dbg = d; e.cpu_rd = crd; e.dbg_rd = drd;
    sb.push_back(e);
  endtask

  // One complete transaction from an IDLE negedge, with cycle-exact checks.
  task automatic txn(input bit d, input bit we, input logic [4:0] a, input logic [7:0] wd,
                     input logic [7:0] crd, input logic [7:0] drd);
    if (d) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    push(d, crd, drd);
    @(negedge clk);
    chk("c1_mem_en", mem_en, 1'b1);
    chk("c1_mem_we", mem_we, we);
    chk("c1_mem_addr", mem_addr, a);
    if (we) chk("c1_mem_wdata", mem_wdata, wd);
    chk("c1_owner", owner, d);
    chk("c1_busy", busy, 1'b1);
    chk("c1_ack", {cpu_ack, dbg_ack}, 2'b00);
    @(negedge clk);
    chk("c2_mem_en", mem_en, 1'b0);
    chk("c2_ack", {cpu_ack, dbg_ack}, 2'b00);
    chk("c2_busy", busy, 1'b1);
    @(negedge clk);
    chk("c3_ack", {cpu_ack, dbg_ack}, d ? 2'b01 : 2'b10);
    chk("c3_mem_en", mem_en, 1'b0);
    cpu_req = 0; dbg_req = 0;
    @(negedge clk);
    chk("c4_busy", busy, 1'b0);
    chk("c4_ack", {cpu_ack, dbg_ack}, 2'b00);
  endtask

  initial begin
    bit seq [10];
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[5] = 8'hA3; mem[7] = 8'h3C; mem[9] = 8'h11;
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs", {cpu_ack, dbg_ack, mem_en, mem_we, owner, busy}, 6'd0);
    chk("rst_mem_addr", mem_addr, 5'd0);
    chk("rst_mem_wdata", mem_wdata, 8'd0);
    chk("rst_cpu_rdata", cpu_rdata, 8'd0);
    chk("rst_dbg_rdata", dbg_rdata, 8'd0);
    rst = 0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // CPU read of addr 5
    txn(0, 0, 5'd5, 8'h00, 8'hA3, 8'h00);
    chk("rd5_cpu_rdata_hold", cpu_rdata, 8'hA3);

    // Debug write 0x5C to 12, then CPU read of 12
    txn(1, 1, 5'd12, 8'h5C, 8'hA3, 8'h00);
    txn(0, 0, 5'd12, 8'h00, 8'h5C, 8'h00);

    // Simultaneous requests: CPU first, debug in the next IDLE window
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd5;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd12;
    push(0, 8'hA3, 8'h00);
    push(1, 8'hA3, 8'h5C);
    @(negedge clk);
    chk("tie_owner_cpu", owner, 1'b0);
    chk("tie_addr_cpu", mem_addr, 5'd5);
    repeat (2) @(negedge clk);
    chk("tie_cpu_ack", cpu_ack, 1'b1);
    cpu_req = 0;
    repeat (2) @(negedge clk);
    chk("tie_owner_dbg", owner, 1'b1);
    chk("tie_addr_dbg", mem_addr, 5'd12);
    chk("tie_mem_en_dbg", mem_en, 1'b1);
    repeat (2) @(negedge clk);
    chk("tie_dbg_ack", dbg_ack, 1'b1);
    dbg_req = 0;
    @(negedge clk);

    // Starvation bound: both held high, C,C,C,C,D repeating
    seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    cpu_req = 1; dbg_req = 1;
    for (int k = 0; k < 10; k++) push(seq[k], 8'hA3, 8'h5C);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_owner_%0d", k), owner, seq[k]);
      chk($sformatf("starve_mem_en_%0d", k), mem_en, 1'b1);
      @(negedge clk);
      chk($sformatf("starve_noack_%0d", k), {cpu_ack, dbg_ack}, 2'b00);
      @(negedge clk);
      chk($sformatf("starve_ack_%0d", k), cpu_ack | dbg_ack, 1'b1);
      if (k == 9) begin cpu_req = 0; dbg_req = 0; end
      @(negedge clk);
      chk($sformatf("starve_idle_%0d", k), busy, 1'b0);
    end

    // Reset during ISSUE: mem_en drops the next cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd7;
    @(negedge clk);
    chk("rstiss_mem_en", mem_en, 1'b1);
    rst = 1;
    @(negedge clk);
    chk("rstiss_mem_en_drop", mem_en, 1'b0);
    chk("rstiss_busy", busy, 1'b0);
    rst = 0; cpu_req = 0;
    @(negedge clk);

    // Reset during RESP of a CPU read: no ack, no capture
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd7;
    @(negedge clk);
    @(negedge clk);
    chk("rstresp_in_resp", busy, 1'b1);
    rst = 1;
    @(negedge clk);
    chk("rstresp_no_ack", cpu_ack, 1'b0);
    chk("rstresp_busy", busy, 1'b0);
    chk("rstresp_cpu_rdata", cpu_rdata, 8'h00);
    rst = 0; cpu_req = 0;
    @(negedge clk);
    chk("rstresp_still_no_ack", cpu_ack, 1'b0);
    txn(0, 0, 5'd7, 8'h00, 8'h3C, 8'h00);

    // Write leaves cpu_rdata unchanged
    txn(0, 0, 5'd9, 8'h00, 8'h11, 8'h00);
    txn(0, 1, 5'd9, 8'hFF, 8'h11, 8'h00);
    chk("wr_cpu_rdata_hold", cpu_rdata, 8'h11);
    txn(0, 0, 5'd9, 8'h00, 8'hFF, 8'h00);

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
